skintone_stream_classifier: RTL and testbench
=============================================

# skintone_stream_classifier

Parametrised, fully pipelined elliptical skin-tone classifier for YCbCr pixel streams. It scores one pixel per cycle with the chroma-ellipse test of the first-generation datapath. It adds:
- configurable fixed-point width;
- run-time programmable ellipse coefficients with safe commit;
- binary-mask mode;
- valid/ready backpressure with a frame-end sideband.

It sits between the pixel source and the result writer.

## Interface
Parameters:
- INT_W, 12, integer bits of the signed fixed-point format, sign bit included.
- FRAC_W, 8, fraction bits. FP_W = INT_W+FRAC_W.

Ports:
- clk  in  1  single clock, all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- pixel_datain  in  24  {Y[23:16], Cb[15:8], Cr[7:0]}, unsigned. Y is ignored; chroma compensation happens upstream.
- pixel_datain_valid  in  1  input beat valid.
- pixel_datain_last  in  1  last pixel of frame, qualified by valid.
- pixel_datain_ready  out  1  block accepts the beat this cycle.
- result_dataout  out  8  skin score, or mask value 0/255.
- result_dataout_valid  out  1  output beat valid.
- result_dataout_last  out  1  delayed copy of pixel_datain_last.
- result_dataout_ready  in  1  downstream accepts the beat.
- cfg_we  in  1  shadow-register write strobe.
- cfg_addr  in  4  register select: 0 CX, 1 CY, 2 COS, 3 SIN, 4 ECX, 5 ECY, 6 A2INV, 7 B2INV, 8 RADIUS, 9 FAC, 10 MODE (bit0 only).
- cfg_wdata  in  FP_W  signed fixed-point value.
- cfg_commit  in  1  request copy of shadow registers to active registers.
- cfg_busy  out  1  commit pending.

## Operation
- Transfer rules:
  - An input transfer occurs when pixel_datain_valid and pixel_datain_ready are both 1.
  - An output transfer occurs when result_dataout_valid and result_dataout_ready are both 1.
- Pipeline advance: adv = !result_dataout_valid | result_dataout_ready. All stage registers and valid/last bits shift only when adv=1. A stall holds every stage unchanged.
- pixel_datain_ready = adv & !cfg_busy & !rst (combinational).
- Arithmetic, all signed FP_W:
  - cb = Cb·2^FRAC_W − CX; cr = Cr·2^FRAC_W − CY.
  - x = COS·cb + SIN·cr; y = COS·cr − SIN·cb.
  - u = x − ECX; v = y − ECY.
  - d = A2INV·u² + B2INV·v².
- Fixed-point multiply: full 2·FP_W product, arithmetic shift right by FRAC_W (floor), then saturate to the signed FP_W range. Adds and subtracts also saturate to signed FP_W.
- Output value:
  - MODE=0: result = d ≤ RADIUS ? sat_u8(floor((RADIUS−d)·FAC / 2^FRAC_W)) : 0. sat_u8 clamps to 0..255.
  - MODE=1: result = d ≤ RADIUS ? 255 : 0.
- Config writes:
  - cfg_we writes cfg_wdata into the shadow register at cfg_addr, any cycle.
  - Addresses 11–15 are ignored.
  - A write to MODE keeps bit0 only.
- Commit:
  - cfg_commit sets cfg_busy. While busy, no new pixels are accepted.
  - The active registers load from shadow on the first cycle with cfg_busy=1 and no valid beat in any stage or on the output. cfg_busy clears the next cycle.
  - cfg_commit while busy: no effect.
  - Shadow writes while busy are captured and included in the pending commit, if written before the load cycle.
- Every beat is computed entirely with the active registers in force when it was accepted. No beat ever sees a mixed coefficient set.
- Reset values:
  - All shadow and active registers 0, MODE 0.
  - All stage valid bits 0; result_dataout 0, result_dataout_valid 0, result_dataout_last 0.
  - cfg_busy 0; pixel_datain_ready 0 during reset.
- Reset mid-operation discards all in-flight beats and any pending commit.

## Timing
- Eight pipeline stages:
  - S1 centre subtract.
  - S2 rotation products.
  - S3 rotation sums.
  - S4 ellipse-centre subtract.
  - S5 squares.
  - S6 axis scaling.
  - S7 sum and radius compare.
  - S8 score multiply / mode select; S8 drives the outputs.
- Latency: a beat accepted in cycle t appears with result_dataout_valid=1 in cycle t+8 when no stalls occur. Each stall cycle adds one cycle.
- Throughput: one pixel per cycle with result_dataout_ready held 1.
- Ordering and last flags are preserved exactly.
- Output beats are held stable while result_dataout_valid=1 and result_dataout_ready=0.
- Commit load occurs at most 9 cycles after cfg_commit with ready held 1. First post-commit beat acceptance is possible the cycle after cfg_busy falls.

## Test plan
Configuration for scenarios 1–3 (Q12.8): CX=CY=128·256, COS=256, SIN=0, ECX=ECY=0, A2INV=B2INV=1, RADIUS=256, FAC=200·256, MODE=0, committed.
1. Pixel Cb=128, Cr=128 -> result 200 at exactly t+8. Then Cb=136, Cr=128 -> 150. Then Cb=148, Cr=128 -> 0 (d=1.5625 > 1).
2. Write MODE=1, commit, then send the scenario-1 pixels -> results 255, 255, 0.
3. Stream 20 pixels back-to-back with the last flag on pixel 19, and randomise result_dataout_ready at 50% -> 20 outputs in order with correct scores. result_dataout_last is set only on the 20th output. Data is held stable across every stall.
4. Assert cfg_commit after changing FAC to 100·256 while 5 beats are in flight -> those 5 beats score with FAC=200 (e.g. 200). pixel_datain_ready stays 0 until drain. The next Cb=128 pixel scores 100.
5. Assert rst for one cycle with the pipeline full -> next cycle: result_dataout_valid=0, cfg_busy=0, all coefficients 0. A subsequent pixel with CX=CY=0 and RADIUS=0 scores 0 (d=0 ≤ 0, FAC=0).
6. Saturation: COS=2047·256, Cb=255, CX=0 -> products clamp to signed FP_W maximum, no wrap. With RADIUS=2047·256 and FAC=2047·256 at the centre pixel -> result 255.

Source files
------------

// File: rtl/skintone_stream_classifier.sv
// rtl/skintone_stream_classifier.sv - eight-stage elliptical chroma skin-tone classifier with valid/ready streaming
module skintone_stream_classifier #(
  parameter int INT_W  = 12,
  parameter int FRAC_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [23:0]             pixel_datain,
  input  logic                    pixel_datain_valid,
  input  logic                    pixel_datain_last,
  output logic                    pixel_datain_ready,
  output logic [7:0]              result_dataout,
  output logic                    result_dataout_valid,
  output logic                    result_dataout_last,
  input  logic                    result_dataout_ready,
  input  logic                    cfg_we,
  input  logic [3:0]              cfg_addr,
  input  logic [INT_W+FRAC_W-1:0] cfg_wdata,
  input  logic                    cfg_commit,
  output logic                    cfg_busy
);

  localparam int FP_W = INT_W + FRAC_W;
  localparam int W2   = 2 * FP_W;
  localparam int NREG = 11;

  localparam logic signed [FP_W-1:0] FP_MAX   = {1'b0, {(FP_W-1){1'b1}}};
  localparam logic signed [FP_W-1:0] FP_MIN   = {1'b1, {(FP_W-1){1'b0}}};
  localparam logic signed [W2-1:0]   WIDE_MAX = W2'(FP_MAX);
  localparam logic signed [W2-1:0]   WIDE_MIN = W2'(FP_MIN);
  localparam logic signed [W2-1:0]   U8_MAX   = W2'(255);

  // Clamp a wide intermediate back into the signed FP_W range.
  function automatic logic signed [FP_W-1:0] sat_wide(input logic signed [W2-1:0] w);
    if (w > WIDE_MAX) return FP_MAX;
    if (w < WIDE_MIN) return FP_MIN;
    return w[FP_W-1:0];
  endfunction

  function automatic logic signed [FP_W-1:0] fp_add(input logic signed [FP_W-1:0] a,
                                                    input logic signed [FP_W-1:0] b);
    return sat_wide(W2'(a) + W2'(b));
  endfunction

  function automatic logic signed [FP_W-1:0] fp_sub(input logic signed [FP_W-1:0] a,
                                                    input logic signed [FP_W-1:0] b);
    return sat_wide(W2'(a) - W2'(b));
  endfunction

  // Full-width product, floor shift back to FP_W scaling, then saturate.
  function automatic logic signed [FP_W-1:0] fp_mul(input logic signed [FP_W-1:0] a,
                                                    input logic signed [FP_W-1:0] b);
    logic signed [W2-1:0] p;
    p = W2'(a) * W2'(b);
    return sat_wide(p >>> FRAC_W);
  endfunction

  // Coefficient storage: shadow takes writes, active feeds the datapath.
  logic signed [FP_W-1:0] shd [0:NREG-1];
  logic signed [FP_W-1:0] act [0:NREG-1];

  logic signed [FP_W-1:0] c_cx, c_cy, c_cos, c_sin, c_ecx, c_ecy;
  logic signed [FP_W-1:0] c_a2inv, c_b2inv, c_radius, c_fac;
  logic                   c_mode;

  assign c_cx     = act[0];
  assign c_cy     = act[1];
  assign c_cos    = act[2];
  assign c_sin    = act[3];
  assign c_ecx    = act[4];
  assign c_ecy    = act[5];
  assign c_a2inv  = act[6];
  assign c_b2inv  = act[7];
  assign c_radius = act[8];
  assign c_fac    = act[9];
  assign c_mode   = act[10][0];

  // Luma and the upper MODE bits carry no information for the classifier.
  logic unused_bits;
  assign unused_bits = ^{pixel_datain[23:16], act[10][FP_W-1:1]};

  // Pipeline handshake; vld[7]/lst[7] belong to the output stage.
  logic [7:0] vld;
  logic [7:0] lst;
  logic       adv;
  logic       take;
  logic       pipe_empty;
  logic       load;

  assign adv                  = !vld[7] || result_dataout_ready;
  assign pixel_datain_ready   = adv && !cfg_busy && !rst;
  assign take                 = pixel_datain_valid && pixel_datain_ready;
  assign pipe_empty           = (vld == 8'd0);
  assign result_dataout_valid = vld[7];
  assign result_dataout_last  = lst[7];

  // Commit handshake: park in PEND until the pipeline has fully drained.
  typedef enum logic {C_IDLE = 1'b0, C_PEND = 1'b1} commit_state_t;
  commit_state_t cstate, cstate_nxt;

  // Commit state register.
  always_ff @(posedge clk) begin
    if (rst) cstate <= C_IDLE;
    else     cstate <= cstate_nxt;
  end

  // Commit next-state and the shadow-to-active load strobe.
  always_comb begin
    cstate_nxt = cstate;
    cfg_busy   = 1'b0;
    load       = 1'b0;
    case (cstate)
      C_IDLE: if (cfg_commit) cstate_nxt = C_PEND;
      C_PEND: begin
        cfg_busy = 1'b1;
        if (pipe_empty) begin
          load       = 1'b1;
          cstate_nxt = C_IDLE;
        end
      end
      default: cstate_nxt = C_IDLE;
    endcase
  end

  // Shadow writes any cycle; active set only changes with an empty pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        shd[i] <= '0;
        act[i] <= '0;
      end
    end else begin
      if (cfg_we && cfg_addr < 4'd10) shd[cfg_addr] <= cfg_wdata;
      else if (cfg_we && cfg_addr == 4'd10) shd[10] <= {{(FP_W-1){1'b0}}, cfg_wdata[0]};
      if (load) begin
        for (int i = 0; i < NREG; i++) act[i] <= shd[i];
      end
    end
  end

  // Datapath stage registers.
  logic signed [FP_W-1:0] s1_cb, s1_cr;
  logic signed [FP_W-1:0] s2_pcc, s2_psr, s2_pcr, s2_psb;
  logic signed [FP_W-1:0] s3_x, s3_y;
  logic signed [FP_W-1:0] s4_u, s4_v;
  logic signed [FP_W-1:0] s5_uu, s5_vv;
  logic signed [FP_W-1:0] s6_au, s6_bv;
  logic                   s7_inside;
  logic signed [FP_W-1:0] s7_diff;

  logic signed [W2-1:0]   cb_wide, cr_wide;
  logic signed [FP_W-1:0] s6_d;

  assign cb_wide = $signed(W2'({pixel_datain[15:8], {FRAC_W{1'b0}}})) - W2'(c_cx);
  assign cr_wide = $signed(W2'({pixel_datain[7:0],  {FRAC_W{1'b0}}})) - W2'(c_cy);
  assign s6_d    = fp_add(s6_au, s6_bv);

  // Arithmetic stages S1..S7, frozen together whenever the output stalls.
  always_ff @(posedge clk) begin
    if (adv) begin
      s1_cb     <= sat_wide(cb_wide);
      s1_cr     <= sat_wide(cr_wide);
      s2_pcc    <= fp_mul(c_cos, s1_cb);
      s2_psr    <= fp_mul(c_sin, s1_cr);
      s2_pcr    <= fp_mul(c_cos, s1_cr);
      s2_psb    <= fp_mul(c_sin, s1_cb);
      s3_x      <= fp_add(s2_pcc, s2_psr);
      s3_y      <= fp_sub(s2_pcr, s2_psb);
      s4_u      <= fp_sub(s3_x, c_ecx);
      s4_v      <= fp_sub(s3_y, c_ecy);
      s5_uu     <= fp_mul(s4_u, s4_u);
      s5_vv     <= fp_mul(s4_v, s4_v);
      s6_au     <= fp_mul(c_a2inv, s5_uu);
      s6_bv     <= fp_mul(c_b2inv, s5_vv);
      s7_inside <= (s6_d <= c_radius);
      s7_diff   <= fp_sub(c_radius, s6_d);
    end
  end

  // Score: integer part of (RADIUS-d)*FAC in fixed point, clamped to a byte.
  logic signed [W2-1:0] score_prod;
  logic signed [W2-1:0] score_int;
  logic [7:0]           score;

  // S8 combinational score / mask selection.
  always_comb begin
    score_prod = W2'(s7_diff) * W2'(c_fac);
    score_int  = score_prod >>> (2 * FRAC_W);
    score      = 8'd0;
    if (s7_inside) begin
      if (c_mode)                     score = 8'hFF;
      else if (score_int > U8_MAX)    score = 8'hFF;
      else if (!score_int[W2-1])      score = score_int[7:0];
    end
  end

  // Valid/last shift chain and the output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld            <= '0;
      lst            <= '0;
      result_dataout <= '0;
    end else if (adv) begin
      vld            <= {vld[6:0], take};
      lst            <= {lst[6:0], take && pixel_datain_last};
      result_dataout <= score;
    end
  end

endmodule

// File: tb/tb_skintone_stream_classifier.sv
// tb/tb_skintone_stream_classifier.sv - scoreboard bench for skintone_stream_classifier
module tb_skintone_stream_classifier;
  localparam int INT_W  = 12;
  localparam int FRAC_W = 8;
  localparam int FP_W   = INT_W + FRAC_W;
  localparam longint MAXV = (longint'(1) <<< (FP_W-1)) - 1;
  localparam longint MINV = -(longint'(1) <<< (FP_W-1));

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [23:0] pixel_datain = '0;
  logic pixel_datain_valid = 1'b0, pixel_datain_last = 1'b0, pixel_datain_ready;
  logic [7:0] result_dataout;
  logic result_dataout_valid, result_dataout_last;
  logic result_dataout_ready = 1'b1;
  logic cfg_we = 1'b0;
  logic [3:0] cfg_addr = '0;
  logic [FP_W-1:0] cfg_wdata = '0;
  logic cfg_commit = 1'b0, cfg_busy;

  always #5 clk = ~clk;

  skintone_stream_classifier #(.INT_W(INT_W), .FRAC_W(FRAC_W)) dut (
    .clk(clk), .rst(rst),
    .pixel_datain(pixel_datain), .pixel_datain_valid(pixel_datain_valid),
    .pixel_datain_last(pixel_datain_last), .pixel_datain_ready(pixel_datain_ready),
    .result_dataout(result_dataout), .result_dataout_valid(result_dataout_valid),
    .result_dataout_last(result_dataout_last), .result_dataout_ready(result_dataout_ready),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_commit(cfg_commit), .cfg_busy(cfg_busy)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int data; bit last; int acc; } exp_t;
  exp_t exp_q[$];

  longint shd_m [0:10];
  longint act_m [0:10];
  bit lat_check = 0;
  bit ready_mode = 0;
  bit stall_all = 0;

  task automatic check(input string name, input longint got, input longint want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, want, $time);
    end
  endtask

  // Reference model: the classifier as plain saturating integer arithmetic.
  function automatic longint msat(input longint x);
    if (x > MAXV) return MAXV;
    if (x < MINV) return MINV;
    return x;
  endfunction

  function automatic longint mmul(input longint a, input longint b);
    return msat((a * b) >>> FRAC_W);
  endfunction

  function automatic int model_score(input int cb8, input int cr8);
    longint cb, cr, x, y, u, v, d, s;
    cb = msat(longint'(cb8) * (longint'(1) <<< FRAC_W) - act_m[0]);
    cr = msat(longint'(cr8) * (longint'(1) <<< FRAC_W) - act_m[1]);
    x  = msat(mmul(act_m[2], cb) + mmul(act_m[3], cr));
    y  = msat(mmul(act_m[2], cr) - mmul(act_m[3], cb));
    u  = msat(x - act_m[4]);
    v  = msat(y - act_m[5]);
    d  = msat(mmul(act_m[6], mmul(u, u)) + mmul(act_m[7], mmul(v, v)));
    if (d > act_m[8]) return 0;
    if (act_m[10] != 0) return 255;
    s = (msat(act_m[8] - d) * act_m[9]) >>> (2 * FRAC_W);
    if (s < 0) return 0;
    if (s > 255) return 255;
    return int'(s);
  endfunction

  // Output-ready driver.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (stall_all)       result_dataout_ready = 1'b0;
      else if (ready_mode) result_dataout_ready = 1'($urandom_range(0, 1));
      else                 result_dataout_ready = 1'b1;
    end
  end

  // Monitor: pops the scoreboard on each output transfer and checks stalls.
  bit prev_stall = 0;
  int prev_data = 0;
  bit prev_last = 0;
  exp_t mon_e;
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 0;
      end else begin
        if (prev_stall) begin
          check("hold_valid", result_dataout_valid, 1);
          check("hold_data", result_dataout, prev_data);
          check("hold_last", result_dataout_last, prev_last);
        end
        if (result_dataout_valid && result_dataout_ready) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_output: got %0d expected no beat", result_dataout);
          end else begin
            mon_e = exp_q.pop_front();
            check("score", result_dataout, mon_e.data);
            check("last", result_dataout_last, mon_e.last);
            if (lat_check) check("latency", cyc - mon_e.acc, 8);
          end
        end
        if (cfg_busy) check("ready_while_busy", pixel_datain_ready, 0);
        prev_stall = result_dataout_valid && !result_dataout_ready;
        prev_data  = result_dataout;
        prev_last  = result_dataout_last;
      end
    end
  end

  // Tasks are entered and left just after a rising edge.
  task automatic send_px(input int cb8, input int cr8, input bit l, input int exp_val);
    int n = 0;
    exp_t e;
    pixel_datain       = {8'($urandom), 8'(cb8), 8'(cr8)};
    pixel_datain_valid = 1'b1;
    pixel_datain_last  = l;
    forever begin
      @(negedge clk);
      if (pixel_datain_ready) break;
      n++;
      if (n > 200) break;
    end
    if (n > 200) begin
      checks++; errors++;
      $display("FAIL accept_timeout: got no ready expected ready within 200 cycles");
    end else begin
      e.data = (exp_val < 0) ? model_score(cb8, cr8) : exp_val;
      e.last = l;
      e.acc  = cyc;
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    pixel_datain_valid = 1'b0;
    pixel_datain_last  = 1'b0;
  endtask

  task automatic cfg_write(input int addr, input longint val);
    cfg_we    = 1'b1;
    cfg_addr  = 4'(addr);
    cfg_wdata = FP_W'(val);
    @(posedge clk); #1;
    cfg_we = 1'b0;
    if (addr < 10)       shd_m[addr] = val;
    else if (addr == 10) shd_m[10]   = val & 1;
  endtask

  task automatic commit_pulse();
    cfg_commit = 1'b1;
    @(posedge clk); #1;
    cfg_commit = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    forever begin
      @(negedge clk);
      n++;
      if (!cfg_busy) break;
      if (n > 300) begin
        checks++; errors++;
        $display("FAIL commit_timeout: got busy expected idle within 300 cycles");
        break;
      end
    end
    if (!ready_mode && !stall_all) check("ready_after_commit", pixel_datain_ready, 1);
    act_m = shd_m;
    @(posedge clk); #1;
  endtask

  task automatic do_commit();
    int n;
    commit_pulse();
    @(negedge clk);
    check("busy_set", cfg_busy, 1);
    @(posedge clk); #1;
    wait_idle(n);
    if (!ready_mode) check("commit_latency_ok", (n + 1 <= 10) ? 1 : 0, 1);
  endtask

  task automatic wait_drain();
    int n = 0;
    forever begin
      @(negedge clk);
      if (exp_q.size() == 0 && !result_dataout_valid) break;
      n++;
      if (n > 1000) begin
        checks++; errors++;
        $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic base_config();
    cfg_write(0, 128 * 256); cfg_write(1, 128 * 256);
    cfg_write(2, 256);       cfg_write(3, 0);
    cfg_write(4, 0);         cfg_write(5, 0);
    cfg_write(6, 1);         cfg_write(7, 1);
    cfg_write(8, 256);       cfg_write(9, 200 * 256);
    cfg_write(10, 0);
    do_commit();
  endtask

  longint rv;
  logic signed [FP_W-1:0] rnd;

  initial begin
    for (int i = 0; i < 11; i++) begin shd_m[i] = 0; act_m[i] = 0; end
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", pixel_datain_ready, 0);
    check("rst_valid", result_dataout_valid, 0);
    check("rst_data", result_dataout, 0);
    check("rst_last", result_dataout_last, 0);
    check("rst_busy", cfg_busy, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed scores with the reference configuration.
    base_config();
    lat_check = 1;
    send_px(128, 128, 0, 200);
    send_px(136, 128, 0, 150);
    send_px(148, 128, 1, 0);
    wait_drain();

    // Binary mask mode.
    cfg_write(10, 1);
    do_commit();
    send_px(128, 128, 0, 255);
    send_px(136, 128, 0, 255);
    send_px(148, 128, 0, 0);
    wait_drain();
    lat_check = 0;

    // Back-to-back stream under random backpressure.
    cfg_write(10, 0);
    do_commit();
    ready_mode = 1;
    for (int i = 0; i < 20; i++)
      send_px(128 + $urandom_range(0, 20), 128 + $urandom_range(0, 20), (i == 19), -1);
    wait_drain();
    ready_mode = 0;

    // Commit with beats in flight, including writes captured while busy.
    for (int i = 0; i < 5; i++) send_px(128, 128, 0, 200);
    cfg_write(9, 50 * 256);
    commit_pulse();
    commit_pulse();
    cfg_write(13, 12345);
    cfg_write(9, 100 * 256);
    begin
      int n;
      wait_idle(n);
    end
    send_px(128, 128, 0, 100);
    wait_drain();

    // Reset with a full, stalled pipeline and a pending commit.
    stall_all = 1;
    for (int i = 0; i < 8; i++) send_px(130, 126, (i == 7), -1);
    commit_pulse();
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("ready_in_reset", pixel_datain_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    stall_all = 0;
    for (int i = 0; i < 11; i++) begin shd_m[i] = 0; act_m[i] = 0; end
    @(negedge clk);
    check("post_rst_valid", result_dataout_valid, 0);
    check("post_rst_busy", cfg_busy, 0);
    @(posedge clk); #1;
    send_px(200, 40, 0, 0);
    wait_drain();

    // Saturation corner.
    cfg_write(0, 0); cfg_write(1, 0);
    cfg_write(2, 2047 * 256); cfg_write(3, 0);
    cfg_write(6, 1); cfg_write(7, 1);
    cfg_write(8, 2047 * 256); cfg_write(9, 2047 * 256);
    do_commit();
    send_px(255, 0, 0, -1);
    send_px(0, 0, 0, 255);
    send_px(255, 255, 0, -1);
    wait_drain();

    // Randomised coefficient sets and pixels against the model.
    for (int r = 0; r < 5; r++) begin
      if (r < 4) begin
        cfg_write(0, longint'($urandom_range(100, 156)) * 256 + $urandom_range(0, 255));
        cfg_write(1, longint'($urandom_range(100, 156)) * 256 + $urandom_range(0, 255));
        cfg_write(2, longint'($urandom_range(0, 512)) - 256);
        cfg_write(3, longint'($urandom_range(0, 512)) - 256);
        cfg_write(4, longint'($urandom_range(0, 2048)) - 1024);
        cfg_write(5, longint'($urandom_range(0, 2048)) - 1024);
        cfg_write(6, $urandom_range(0, 16));
        cfg_write(7, $urandom_range(0, 16));
        cfg_write(8, $urandom_range(0, 8192));
        cfg_write(9, $urandom_range(0, 400 * 256));
        cfg_write(10, (r == 3) ? 1 : 0);
      end else begin
        for (int a = 0; a < 10; a++) begin
          rnd = FP_W'($urandom);
          rv = rnd;
          cfg_write(a, rv);
        end
        cfg_write(10, 0);
      end
      cfg_write(11, $urandom_range(0, 1000));
      do_commit();
      ready_mode = 1;
      for (int i = 0; i < 30; i++) begin
        if (r < 4) send_px(128 + $urandom_range(0, 60) - 30, 128 + $urandom_range(0, 60) - 30,
                           ($urandom_range(0, 7) == 0), -1);
        else       send_px($urandom_range(0, 255), $urandom_range(0, 255),
                           ($urandom_range(0, 7) == 0), -1);
      end
      wait_drain();
      ready_mode = 0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #600000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
